caravel: RTL and testbench

CARAVEL -- requirements
Module: caravel

---
 rtl/caravel_led_pkg.sv | 20 ++
 rtl/ws2812_encoder.sv | 99 +++++++++
 rtl/caravel.sv | 128 ++++++++++++
 tb/tb_caravel.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caravel_led_pkg.sv
// Shared definitions for the caravel LED block: register offsets, CTRL bit
// positions and the serial encoder state encoding.
package caravel_led_pkg;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_CHECK    = 8'h04;
  localparam logic [7:0] ADDR_COLOR    = 8'h08;
  localparam logic [7:0] ADDR_NUM_LEDS = 8'h0C;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_BUSY_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_HIGH = 2'd1,
    ST_SEND_LOW  = 2'd2,
    ST_LATCH     = 2'd3
  } enc_state_e;

endpackage

// File: rtl/ws2812_encoder.sv
// WS2812-style serial encoder: sends (num_leds+1) frames of {color,color,color}
// MSB first, then holds the line low for the latch period. State is exported on state_o.
module ws2812_encoder
  import caravel_led_pkg::*;
#(
  parameter int T0H_CYC  = 16,
  parameter int T1H_CYC  = 32,
  parameter int TBIT_CYC = 50,
  parameter int TRST_CYC = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] color_i,
  input  logic [5:0] num_leds_i,
  output logic       dout_o,
  output enc_state_e state_o
);

  localparam int CNT_MAX = (TBIT_CYC > TRST_CYC) ? TBIT_CYC : TRST_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] T0H_LAST  = CW'(T0H_CYC - 1);
  localparam logic [CW-1:0] T1H_LAST  = CW'(T1H_CYC - 1);
  localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] TRST_LAST = CW'(TRST_CYC - 1);
  localparam logic [CW-1:0] CNT_INC   = CW'(1);

  enc_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0]   bits_left_q, bits_left_d;
  logic [23:0]   shift_q, shift_d;
  logic [CW-1:0] high_last;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bits_left_d = bits_left_q;
    shift_d     = shift_q;
    high_last   = shift_q[23] ? T1H_LAST : T0H_LAST;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_SEND_HIGH;
          cnt_d       = '0;
          shift_d     = {3{color_i}};
          // (n+1)*24 - 1 bits remain after the first one
          bits_left_d = 11'(num_leds_i) * 11'd24 + 11'd23;
        end
      end
      ST_SEND_HIGH: begin
        cnt_d = cnt_q + CNT_INC;
        if (cnt_q == high_last) state_d = ST_SEND_LOW;
      end
      ST_SEND_LOW: begin
        if (cnt_q == TBIT_LAST) begin
          cnt_d = '0;
          if (bits_left_q == '0) begin
            state_d = ST_LATCH;
          end else begin
            state_d     = ST_SEND_HIGH;
            bits_left_d = bits_left_q - 11'd1;
            // rotating the 24-bit frame restores it after every LED
            shift_d     = {shift_q[22:0], shift_q[23]};
          end
        end else begin
          cnt_d = cnt_q + CNT_INC;
        end
      end
      ST_LATCH: begin
        if (cnt_q == TRST_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_INC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bits_left_q <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_left_q <= bits_left_d;
      shift_q     <= shift_d;
    end
  end

  assign dout_o  = (state_q == ST_SEND_HIGH);
  assign state_o = state_q;

endmodule

// File: rtl/caravel.sv
// Caravel user block: Wishbone LED registers driving user pads.
// Optional serial LED encoder is compiled in with `define LED_SERIAL_EN.
module caravel
  import caravel_led_pkg::*;
#(
  parameter int T0H_CYC  = 16,
  parameter int T1H_CYC  = 32,
  parameter int TBIT_CYC = 50,
  parameter int TRST_CYC = 2000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb
);

  // Wishbone: ack_q rises the cycle after cyc&stb and lasts one cycle; a write
  // commits at the end of the ack cycle, so its effect is visible one cycle later.
  logic        ack_q, ack_d;
  logic [15:0] check_q, check_d;
  logic [7:0]  color_q, color_d;
  logic [5:0]  num_leds_q, num_leds_d;
  logic        pixel_q, pixel_d;

  logic        req, wr_en, start, busy, line;
  logic [7:0]  offs;
  logic [31:0] rdata;
  enc_state_e  enc_state;
  logic        unused_wb;

  assign req       = wbs_cyc_i & wbs_stb_i;
  assign offs      = wbs_adr_i[7:0];
  assign wr_en     = ack_q & req & wbs_we_i;
  assign start     = wr_en & (offs == ADDR_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_START_BIT];
  assign unused_wb = ^{wbs_adr_i[31:8], wbs_sel_i[3:2], wbs_dat_i[31:16]};

`ifdef LED_SERIAL_EN
  ws2812_encoder #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .TBIT_CYC(TBIT_CYC),
    .TRST_CYC(TRST_CYC)
  ) u_enc (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .start_i   (start),
    .color_i   (color_q),
    .num_leds_i(num_leds_q),
    .dout_o    (line),
    .state_o   (enc_state)
  );
`else
  localparam int unused_timing = T0H_CYC + T1H_CYC + TBIT_CYC + TRST_CYC;
  logic unused_start;
  assign unused_start = start;
  assign enc_state    = ST_IDLE;
  assign line         = 1'b0;
`endif

  assign busy = (enc_state != ST_IDLE);

  always_comb begin
    ack_d      = req & ~ack_q;
    check_d    = check_q;
    color_d    = color_q;
    num_leds_d = num_leds_q;
    pixel_d    = 1'b0;
    if (wr_en) begin
      unique case (offs)
        ADDR_CHECK: begin
          if (wbs_sel_i[0]) check_d[7:0]  = wbs_dat_i[7:0];
          if (wbs_sel_i[1]) check_d[15:8] = wbs_dat_i[15:8];
        end
        ADDR_COLOR: begin
          if (wbs_sel_i[0]) color_d = wbs_dat_i[7:0];
          pixel_d = 1'b1;
        end
        ADDR_NUM_LEDS: begin
          if (wbs_sel_i[0]) num_leds_d = wbs_dat_i[5:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (ack_q) begin
      unique case (offs)
        ADDR_CTRL:     rdata[CTRL_BUSY_BIT] = busy;
        ADDR_CHECK:    rdata[15:0] = check_q;
        ADDR_COLOR:    rdata[7:0]  = color_q;
        ADDR_NUM_LEDS: rdata[5:0]  = num_leds_q;
        default:       rdata = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      check_q    <= '0;
      color_q    <= '0;
      num_leds_q <= '0;
      pixel_q    <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      check_q    <= check_d;
      color_q    <= color_d;
      num_leds_q <= num_leds_d;
      pixel_q    <= pixel_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdata;
  assign io_out    = {6'b0, check_q, 6'b0, line, pixel_q, color_q};
  assign io_oeb    = {6'h3F, 32'h0};

endmodule

// File: tb/tb_caravel.sv
// Directed bench for caravel: Wishbone register behaviour, pad mapping,
// serial LED encoding (when LED_SERIAL_EN is defined) and asynchronous reset.
module tb_caravel;
  import caravel_led_pkg::*;

  localparam int T0H     = 16;
  localparam int T1H     = 32;
  localparam int TBIT    = 36;
  localparam int TRST    = 2000;
  localparam int LOW_LIM = TBIT + 24;

  logic        clk, rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [37:0] io_out, io_oeb;

  caravel #(
    .T0H_CYC (T0H),
    .T1H_CYC (T1H),
    .TBIT_CYC(TBIT),
    .TRST_CYC(TRST)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .io_out   (io_out),
    .io_oeb   (io_oeb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [37:0] ack_io;
  int          last_lat;
  logic        mon_done;
  int          nbits, nbad, busy_drop, n_reads;
  logic [23:0] last24;
  logic        tout;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
    int lat;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = 0;
    while (ack !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (ack !== 1'b1) check_eq("ack_timeout", 64'(ack), 64'd1);
    r        = rdat;
    ack_io   = io_out;
    last_lat = lat;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    check_eq("ack_single_cycle", 64'(ack), 64'd0);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_cycle(a, 1'b1, d, s, dummy);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    wb_cycle(a, 1'b0, 32'h0, 4'hF, r);
  endtask

  // Measures high/low run lengths on io_out[9]; a low run of LOW_LIM ends the stream.
  task automatic decode_bits(output int nb, output logic [23:0] val, output int bad,
                             output logic to);
    int hi, lo, wt;
    logic done;
    nb = 0; val = '0; bad = 0; to = 1'b0; wt = 0; done = 1'b0;
    while (io_out[9] !== 1'b1 && wt < 200) begin
      @(posedge clk); #1;
      wt++;
    end
    if (io_out[9] !== 1'b1) begin
      to = 1'b1;
    end else begin
      while (!done) begin
        hi = 0;
        while (io_out[9] === 1'b1 && hi < 100) begin
          @(posedge clk); #1;
          hi++;
        end
        if (hi == T1H) val = {val[22:0], 1'b1};
        else if (hi == T0H) val = {val[22:0], 1'b0};
        else bad++;
        nb++;
        lo = 0;
        while (io_out[9] !== 1'b1 && lo < LOW_LIM) begin
          @(posedge clk); #1;
          lo++;
        end
        if (lo >= LOW_LIM) done = 1'b1;
        else if (hi + lo != TBIT) bad++;
        if (hi >= 100 || nb > 2000) begin
          bad++;
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    int highs, w;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    mon_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_io_out", 64'(io_out), 64'd0);
    check_eq("rst_io_oeb", 64'(io_oeb), 64'h3F_0000_0000);
    check_eq("rst_ack", 64'(ack), 64'd0);
    rst = 1'b0;

    // CHECK register and its pad mirror
    wb_write(32'h04, 32'h0000_AB60, 4'hF);
    check_eq("check_ack_cycle_old", 64'(ack_io[31:16]), 64'h0);
    check_eq("check_ab60", 64'(io_out[31:16]), 64'hAB60);
    wb_write(32'h04, 32'h0000_AB61, 4'hF);
    check_eq("check_ack_cycle_ab60", 64'(ack_io[31:16]), 64'hAB60);
    check_eq("check_ab61", 64'(io_out[31:16]), 64'hAB61);
    wb_write(32'h04, 32'h0000_FFFF, 4'b0010);
    check_eq("check_sel_hi", 64'(io_out[31:16]), 64'hFF61);
    wb_read(32'hFFFF_FF04, r);
    check_eq("check_read_upper_adr", 64'(r), 64'h0000_FF61);

    // COLOR register and pixel_write pulse
    wb_write(32'h08, 32'h0000_005A, 4'hF);
    check_eq("color_pixel_ack_cycle", 64'(ack_io[8]), 64'd0);
    check_eq("color_pad", 64'(io_out[7:0]), 64'h5A);
    check_eq("pixel_pulse", 64'(io_out[8]), 64'd1);
    @(posedge clk); #1;
    check_eq("pixel_pulse_end", 64'(io_out[8]), 64'd0);
    wb_read(32'h08, r);
    check_eq("color_read", 64'(r), 64'h0000_005A);
    check_eq("pixel_none_on_read", 64'(io_out[8]), 64'd0);
    check_eq("unused_pads", 64'({io_out[37:32], io_out[15:10]}), 64'd0);

    // NUM_LEDS width and byte lane
    wb_write(32'h0C, 32'hFFFF_FFFF, 4'hF);
    wb_read(32'h0C, r);
    check_eq("num_leds_mask", 64'(r), 64'h3F);
    wb_write(32'h0C, 32'h0, 4'b1110);
    wb_read(32'h0C, r);
    check_eq("num_leds_sel", 64'(r), 64'h3F);
    wb_write(32'h0C, 32'h0, 4'hF);

    // unmapped offset and idle CTRL
    wb_read(32'h40, r);
    check_eq("unmapped_data", 64'(r), 64'd0);
    check_eq("unmapped_latency", 64'(last_lat), 64'd1);
    wb_read(32'h00, r);
    check_eq("ctrl_idle", 64'(r), 64'd0);

`ifdef LED_SERIAL_EN
    // one LED, COLOR=0x80
    wb_write(32'h08, 32'h80, 4'hF);
    wb_write(32'h00, 32'h1, 4'hF);
    decode_bits(nbits, last24, nbad, tout);
    check_eq("one_led_timeout", 64'(tout), 64'd0);
    check_eq("one_led_nbits", 64'(nbits), 64'd24);
    check_eq("one_led_bad_widths", 64'(nbad), 64'd0);
    check_eq("one_led_value", 64'(last24), 64'h808080);
    highs = 0;
    repeat (1948) begin
      @(posedge clk); #1;
      if (io_out[9] !== 1'b0) highs++;
    end
    check_eq("latch_line_low", 64'(highs), 64'd0);
    wb_read(32'h00, r);
    check_eq("latch_busy", 64'(r), 64'h2);
    repeat (17) @(posedge clk);
    wb_read(32'h00, r);
    check_eq("latch_done_idle", 64'(r), 64'h0);

    // full string of 64 LEDs, with a start and register writes mid-flight
    wb_write(32'h08, 32'hA5, 4'hF);
    wb_write(32'h0C, 32'h3F, 4'hF);
    wb_write(32'h00, 32'h1, 4'hF);
    mon_done = 1'b0; busy_drop = 0; n_reads = 0;
    fork
      begin
        decode_bits(nbits, last24, nbad, tout);
        mon_done = 1'b1;
      end
      begin
        logic [31:0] rr;
        int k;
        k = 0;
        while (!mon_done && k < 100) begin
          repeat (1000) @(posedge clk);
          if (!mon_done) begin
            wb_read(32'h00, rr);
            n_reads++;
            if (rr !== 32'h2) busy_drop++;
            if (k == 5) wb_write(32'h00, 32'h1, 4'hF);
            if (k == 10) begin
              wb_write(32'h08, 32'h3C, 4'hF);
              wb_write(32'h04, 32'hBEEF, 4'hF);
            end
          end
          k++;
        end
      end
    join
    check_eq("string_timeout", 64'(tout), 64'd0);
    check_eq("string_nbits", 64'(nbits), 64'd1536);
    check_eq("string_bad_widths", 64'(nbad), 64'd0);
    check_eq("string_frame_held", 64'(last24), 64'hA5A5A5);
    check_eq("string_busy_drops", 64'(busy_drop), 64'd0);
    check_eq("string_reads_enough", 64'(n_reads >= 40), 64'd1);
    check_eq("string_color_pad_live", 64'(io_out[7:0]), 64'h3C);
    check_eq("string_check_pad_live", 64'(io_out[31:16]), 64'hBEEF);
    w = 0;
    wb_read(32'h00, r);
    while (r[1] === 1'b1 && w < 40) begin
      repeat (100) @(posedge clk);
      wb_read(32'h00, r);
      w++;
    end
    check_eq("string_busy_clears", 64'(r), 64'h0);
`else
    wb_write(32'h00, 32'h1, 4'hF);
    wb_read(32'h00, r);
    check_eq("no_enc_busy", 64'(r), 64'd0);
    highs = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (io_out[9] !== 1'b0) highs++;
    end
    check_eq("no_enc_line_low", 64'(highs), 64'd0);
`endif

    // asynchronous reset during a transmission
    wb_write(32'h04, 32'h1234, 4'hF);
    wb_write(32'h08, 32'hFF, 4'hF);
    wb_write(32'h0C, 32'h03, 4'hF);
    wb_write(32'h00, 32'h1, 4'hF);
`ifdef LED_SERIAL_EN
    w = 0;
    while (io_out[9] !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("rst_test_line_active", 64'(io_out[9]), 64'd1);
    repeat (300) @(posedge clk);
    #1;
    wb_read(32'h00, r);
    check_eq("rst_test_busy_before", 64'(r), 64'h2);
`else
    repeat (300) @(posedge clk);
`endif
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("midframe_rst_io_out", 64'(io_out), 64'd0);
    check_eq("midframe_rst_ack", 64'(ack), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wb_read(32'h00, r);
    check_eq("post_rst_ctrl", 64'(r), 64'd0);
    wb_read(32'h04, r);
    check_eq("post_rst_check", 64'(r), 64'd0);
    wb_read(32'h08, r);
    check_eq("post_rst_color", 64'(r), 64'd0);
    wb_read(32'h0C, r);
    check_eq("post_rst_num_leds", 64'(r), 64'd0);
    highs = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (io_out[9] !== 1'b0) highs++;
    end
    check_eq("post_rst_line_low", 64'(highs), 64'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
